ddr_hp_bridge: RTL and testbench

DDR_HP_BRIDGE -- requirements
Module: ddr_hp_bridge

---
 rtl/ddr_hp_bridge.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ddr_hp_bridge.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_hp_bridge.sv
// AXI bridge from the shim slave port onto a Zynq HP slave port: AR/AW register slices,
// address windowing, outstanding-burst throttling and AW-before-W gating.
// Optional statistics outputs are compiled in by defining DDR_HP_BRIDGE_STATS_EN.

module ddr_hp_bridge #(
   parameter int         ADDR_W   = 32,
   parameter int         DATA_W   = 64,
   parameter int         ID_W     = 6,
   parameter int         MAX_OUT  = 8,
   parameter logic [3:0] WIN_BASE = 4'h1
) (
   input  logic                clock,
   input  logic                reset_n,

   // upstream read address
   input  logic                s_ar_valid,
   output logic                s_ar_ready,
   input  logic [ADDR_W-1:0]   s_ar_addr,
   input  logic [ID_W-1:0]     s_ar_id,
   input  logic [7:0]          s_ar_len,
   input  logic [2:0]          s_ar_size,

   // upstream write address
   input  logic                s_aw_valid,
   output logic                s_aw_ready,
   input  logic [ADDR_W-1:0]   s_aw_addr,
   input  logic [ID_W-1:0]     s_aw_id,
   input  logic [7:0]          s_aw_len,
   input  logic [2:0]          s_aw_size,

   // upstream write data
   input  logic                s_w_valid,
   output logic                s_w_ready,
   input  logic [DATA_W-1:0]   s_w_data,
   input  logic                s_w_last,

   // upstream write response
   output logic                s_b_valid,
   input  logic                s_b_ready,
   output logic [ID_W-1:0]     s_b_id,
   output logic [1:0]          s_b_resp,

   // upstream read data
   output logic                s_r_valid,
   input  logic                s_r_ready,
   output logic [DATA_W-1:0]   s_r_data,
   output logic [ID_W-1:0]     s_r_id,
   output logic                s_r_last,
   output logic [1:0]          s_r_resp,

   // downstream read address
   output logic                m_ar_valid,
   input  logic                m_ar_ready,
   output logic [ADDR_W-1:0]   m_ar_addr,
   output logic [ID_W-1:0]     m_ar_id,
   output logic [7:0]          m_ar_len,
   output logic [2:0]          m_ar_size,
   output logic [1:0]          m_ar_burst,

   // downstream write address
   output logic                m_aw_valid,
   input  logic                m_aw_ready,
   output logic [ADDR_W-1:0]   m_aw_addr,
   output logic [ID_W-1:0]     m_aw_id,
   output logic [7:0]          m_aw_len,
   output logic [2:0]          m_aw_size,
   output logic [1:0]          m_aw_burst,

   // downstream write data
   output logic                m_w_valid,
   input  logic                m_w_ready,
   output logic [DATA_W-1:0]   m_w_data,
   output logic                m_w_last,
   output logic [DATA_W/8-1:0] m_w_strb,

   // downstream write response
   input  logic                m_b_valid,
   output logic                m_b_ready,
   input  logic [ID_W-1:0]     m_b_id,
   input  logic [1:0]          m_b_resp,

   // downstream read data
   input  logic                m_r_valid,
   output logic                m_r_ready,
   input  logic [DATA_W-1:0]   m_r_data,
   input  logic [ID_W-1:0]     m_r_id,
   input  logic                m_r_last,
   input  logic [1:0]          m_r_resp,

`ifdef DDR_HP_BRIDGE_STATS_EN
   output logic [31:0]         stat_rd_bursts,
   output logic [31:0]         stat_wr_bursts,
`endif

   // internal state, exported for checkers
   output logic [3:0]          dbg_rd_cnt,
   output logic [3:0]          dbg_wr_cnt,
   output logic [3:0]          dbg_wb_cnt,
   output logic                dbg_ar_full,
   output logic                dbg_aw_full
);

   // Every channel uses AXI valid/ready: a beat transfers on a rising clock edge where
   // valid and ready are both high; valid never waits on ready, ready may depend on valid.

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);
   localparam logic [3:0] CNT_TOP = 4'hF;
   localparam logic [1:0] BURST_INCR = 2'b01;

   logic                ar_full;
   logic [ADDR_W-5:0]   ar_addr_q;
   logic [ID_W-1:0]     ar_id_q;
   logic [7:0]          ar_len_q;
   logic [2:0]          ar_size_q;

   logic                aw_full;
   logic [ADDR_W-5:0]   aw_addr_q;
   logic [ID_W-1:0]     aw_id_q;
   logic [7:0]          aw_len_q;
   logic [2:0]          aw_size_q;

   logic [3:0]          rd_cnt;
   logic [3:0]          wr_cnt;
   logic [3:0]          wb_cnt;

   logic                ar_s_hs;
   logic                ar_m_hs;
   logic                aw_s_hs;
   logic                aw_m_hs;
   logic                r_last_hs;
   logic                b_hs;
   logic                w_last_hs;
   logic                w_open;

   // The window base replaces the top nibble, so the incoming top bits are never used.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^{s_ar_addr[ADDR_W-1:ADDR_W-4], s_aw_addr[ADDR_W-1:ADDR_W-4]};

   assign ar_s_hs   = s_ar_valid && s_ar_ready;
   assign ar_m_hs   = m_ar_valid && m_ar_ready;
   assign aw_s_hs   = s_aw_valid && s_aw_ready;
   assign aw_m_hs   = m_aw_valid && m_aw_ready;
   assign r_last_hs = m_r_valid && m_r_ready && m_r_last;
   assign b_hs      = m_b_valid && m_b_ready;
   assign w_last_hs = m_w_valid && m_w_ready && s_w_last;

   // ---------------- AR slice ----------------
   assign s_ar_ready = reset_n && (!ar_full || ar_m_hs);
   assign m_ar_valid = ar_full && (rd_cnt < MAX_CNT);
   assign m_ar_addr  = {WIN_BASE, ar_addr_q};
   assign m_ar_id    = ar_id_q;
   assign m_ar_len   = ar_len_q;
   assign m_ar_size  = ar_size_q;
   assign m_ar_burst = BURST_INCR;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ar_full   <= 1'b0;
         ar_addr_q <= '0;
         ar_id_q   <= '0;
         ar_len_q  <= '0;
         ar_size_q <= '0;
      end else if (ar_s_hs) begin
         ar_full   <= 1'b1;
         ar_addr_q <= s_ar_addr[ADDR_W-5:0];
         ar_id_q   <= s_ar_id;
         ar_len_q  <= s_ar_len;
         ar_size_q <= s_ar_size;
      end else if (ar_m_hs) begin
         ar_full   <= 1'b0;
      end
   end

   // ---------------- AW slice ----------------
   assign s_aw_ready = reset_n && (!aw_full || aw_m_hs);
   assign m_aw_valid = aw_full && (wr_cnt < MAX_CNT);
   assign m_aw_addr  = {WIN_BASE, aw_addr_q};
   assign m_aw_id    = aw_id_q;
   assign m_aw_len   = aw_len_q;
   assign m_aw_size  = aw_size_q;
   assign m_aw_burst = BURST_INCR;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         aw_full   <= 1'b0;
         aw_addr_q <= '0;
         aw_id_q   <= '0;
         aw_len_q  <= '0;
         aw_size_q <= '0;
      end else if (aw_s_hs) begin
         aw_full   <= 1'b1;
         aw_addr_q <= s_aw_addr[ADDR_W-5:0];
         aw_id_q   <= s_aw_id;
         aw_len_q  <= s_aw_len;
         aw_size_q <= s_aw_size;
      end else if (aw_m_hs) begin
         aw_full   <= 1'b0;
      end
   end

   // ---------------- outstanding counters ----------------
   // A decrement arriving at zero is a downstream protocol error and is dropped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt <= 4'd0;
      end else if (ar_m_hs && !r_last_hs) begin
         rd_cnt <= rd_cnt + 4'd1;
      end else if (!ar_m_hs && r_last_hs && rd_cnt != 4'd0) begin
         rd_cnt <= rd_cnt - 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_cnt <= 4'd0;
      end else if (aw_m_hs && !b_hs) begin
         wr_cnt <= wr_cnt + 4'd1;
      end else if (!aw_m_hs && b_hs && wr_cnt != 4'd0) begin
         wr_cnt <= wr_cnt - 4'd1;
      end
   end

   // Bursts granted downstream whose last W beat has not gone yet; saturates rather than wraps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_cnt <= 4'd0;
      end else if (aw_m_hs && !w_last_hs && wb_cnt != CNT_TOP) begin
         wb_cnt <= wb_cnt + 4'd1;
      end else if (!aw_m_hs && w_last_hs && wb_cnt != 4'd0) begin
         wb_cnt <= wb_cnt - 4'd1;
      end
   end

   // ---------------- W gating ----------------
   // wb_cnt only rises on the edge after the AW handshake, so W never overtakes its AW.
   assign w_open    = (wb_cnt != 4'd0);
   assign m_w_valid = s_w_valid && w_open;
   assign s_w_ready = m_w_ready && w_open;
   assign m_w_data  = s_w_data;
   assign m_w_last  = s_w_last;
   assign m_w_strb  = '1;

   // ---------------- R and B pass-through ----------------
   assign s_r_valid = m_r_valid;
   assign m_r_ready = s_r_ready;
   assign s_r_data  = m_r_data;
   assign s_r_id    = m_r_id;
   assign s_r_last  = m_r_last;
   assign s_r_resp  = m_r_resp;

   assign s_b_valid = m_b_valid;
   assign m_b_ready = s_b_ready;
   assign s_b_id    = m_b_id;
   assign s_b_resp  = m_b_resp;

`ifdef DDR_HP_BRIDGE_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_rd_bursts <= 32'd0;
         stat_wr_bursts <= 32'd0;
      end else begin
         if (ar_m_hs) stat_rd_bursts <= stat_rd_bursts + 32'd1;
         if (aw_m_hs) stat_wr_bursts <= stat_wr_bursts + 32'd1;
      end
   end
`endif

   assign dbg_rd_cnt  = rd_cnt;
   assign dbg_wr_cnt  = wr_cnt;
   assign dbg_wb_cnt  = wb_cnt;
   assign dbg_ar_full = ar_full;
   assign dbg_aw_full = aw_full;

endmodule

// File: tb/tb_ddr_hp_bridge.sv
// Bench for ddr_hp_bridge: vector table, directed multi-cycle sequences and a randomized
// run against a transaction-level model (slice queues plus outstanding-burst tallies).

module tb_ddr_hp_bridge;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 64;
   localparam int ID_W    = 6;
   localparam int MAX_OUT = 8;

   logic clock, reset_n;

   logic s_ar_valid, s_ar_ready; logic [31:0] s_ar_addr; logic [5:0] s_ar_id; logic [7:0] s_ar_len; logic [2:0] s_ar_size;
   logic s_aw_valid, s_aw_ready; logic [31:0] s_aw_addr; logic [5:0] s_aw_id; logic [7:0] s_aw_len; logic [2:0] s_aw_size;
   logic s_w_valid, s_w_ready; logic [63:0] s_w_data; logic s_w_last;
   logic s_b_valid, s_b_ready; logic [5:0] s_b_id; logic [1:0] s_b_resp;
   logic s_r_valid, s_r_ready; logic [63:0] s_r_data; logic [5:0] s_r_id; logic s_r_last; logic [1:0] s_r_resp;
   logic m_ar_valid, m_ar_ready; logic [31:0] m_ar_addr; logic [5:0] m_ar_id; logic [7:0] m_ar_len; logic [2:0] m_ar_size; logic [1:0] m_ar_burst;
   logic m_aw_valid, m_aw_ready; logic [31:0] m_aw_addr; logic [5:0] m_aw_id; logic [7:0] m_aw_len; logic [2:0] m_aw_size; logic [1:0] m_aw_burst;
   logic m_w_valid, m_w_ready; logic [63:0] m_w_data; logic m_w_last; logic [7:0] m_w_strb;
   logic m_b_valid, m_b_ready; logic [5:0] m_b_id; logic [1:0] m_b_resp;
   logic m_r_valid, m_r_ready; logic [63:0] m_r_data; logic [5:0] m_r_id; logic m_r_last; logic [1:0] m_r_resp;
   logic [3:0] dbg_rd_cnt, dbg_wr_cnt, dbg_wb_cnt;
   logic dbg_ar_full, dbg_aw_full;
`ifdef DDR_HP_BRIDGE_STATS_EN
   logic [31:0] stat_rd_bursts, stat_wr_bursts;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [5:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
   } req_t;

   typedef struct {
      logic [31:0] addr;
      logic [5:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [31:0] exp_addr;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int ar_hs_cnt = 0;

   ddr_hp_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT), .WIN_BASE(4'h1)) dut (
      .clock(clock), .reset_n(reset_n),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
      .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_last(s_w_last),
      .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id), .s_r_last(s_r_last), .s_r_resp(s_r_resp),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_last(m_w_last), .m_w_strb(m_w_strb),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id), .m_r_last(m_r_last), .m_r_resp(m_r_resp),
`ifdef DDR_HP_BRIDGE_STATS_EN
      .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts),
`endif
      .dbg_rd_cnt(dbg_rd_cnt), .dbg_wr_cnt(dbg_wr_cnt), .dbg_wb_cnt(dbg_wb_cnt),
      .dbg_ar_full(dbg_ar_full), .dbg_aw_full(dbg_aw_full)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want run complete");
      $fatal(1, "watchdog expired");
   end

   always @(posedge clock) begin
      if (m_ar_valid && m_ar_ready) ar_hs_cnt <= ar_hs_cnt + 1;
   end

   // ---------------- helpers / drivers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      s_ar_valid = 0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0; s_ar_size = '0;
      s_aw_valid = 0; s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0; s_aw_size = '0;
      s_w_valid = 0; s_w_data = '0; s_w_last = 0;
      s_b_ready = 0; s_r_ready = 0;
      m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0;
      m_b_valid = 0; m_b_id = '0; m_b_resp = '0;
      m_r_valid = 0; m_r_data = '0; m_r_id = '0; m_r_last = 0; m_r_resp = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
      bit done = 0;
      s_ar_valid = 1'b1; s_ar_addr = a; s_ar_id = id; s_ar_len = len; s_ar_size = 3'd3;
      for (int k = 0; k < 64 && !done; k++) begin
         #2;
         if (s_ar_ready) done = 1;
         tick();
      end
      s_ar_valid = 1'b0;
      chk("ar_accept", 64'(done), 64'd1);
   endtask

   task automatic send_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
      bit done = 0;
      s_aw_valid = 1'b1; s_aw_addr = a; s_aw_id = id; s_aw_len = len; s_aw_size = 3'd3;
      for (int k = 0; k < 64 && !done; k++) begin
         #2;
         if (s_aw_ready) done = 1;
         tick();
      end
      s_aw_valid = 1'b0;
      chk("aw_accept", 64'(done), 64'd1);
   endtask

   // ---------------- scoreboard / model state ----------------
   req_t ar_q[$];
   req_t aw_q[$];
   int   rd_out, wr_out, wb_out, st_rd, st_wr;

   function automatic int clamp15(input int v);
      if (v < 0) return 0;
      if (v > 15) return 15;
      return v;
   endfunction

   vec_t vecs[6];

   initial begin
      logic [63:0] wdata [4];
      int base;

      vecs[0] = '{32'h0ABC_D000, 6'd3,  8'd7,   3'd3, 32'h1ABC_D000};
      vecs[1] = '{32'hFFFF_FFFF, 6'd63, 8'd255, 3'd7, 32'h1FFF_FFFF};
      vecs[2] = '{32'h1000_0000, 6'd0,  8'd0,   3'd0, 32'h1000_0000};
      vecs[3] = '{32'h0000_0000, 6'd1,  8'd1,   3'd2, 32'h1000_0000};
      vecs[4] = '{32'hE123_4567, 6'd42, 8'd15,  3'd3, 32'h1123_4567};
      vecs[5] = '{32'h2FFF_FFF8, 6'd21, 8'd3,   3'd3, 32'h1FFF_FFF8};

      // reset state with every upstream valid and downstream ready pushed high
      idle_inputs();
      reset_n = 1'b0;
      s_ar_valid = 1; s_aw_valid = 1; s_w_valid = 1;
      m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1;
      #3;
      chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
      chk("rst_s_aw_ready", 64'(s_aw_ready), 64'd0);
      chk("rst_s_w_ready",  64'(s_w_ready),  64'd0);
      chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
      chk("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
      chk("rst_m_w_valid",  64'(m_w_valid),  64'd0);
      chk("rst_rd_cnt", 64'(dbg_rd_cnt), 64'd0);
      chk("rst_wr_cnt", 64'(dbg_wr_cnt), 64'd0);
      chk("rst_wb_cnt", 64'(dbg_wb_cnt), 64'd0);
      do_reset();

      // ---- vector table: AR and AW translated in parallel, then R/B returned ----
      foreach (vecs[i]) begin
         s_ar_valid = 1; s_ar_addr = vecs[i].addr; s_ar_id = vecs[i].id; s_ar_len = vecs[i].len; s_ar_size = vecs[i].size;
         s_aw_valid = 1; s_aw_addr = vecs[i].addr; s_aw_id = vecs[i].id; s_aw_len = vecs[i].len; s_aw_size = vecs[i].size;
         m_ar_ready = 1; m_aw_ready = 1;
         #2;
         chk("vec_ar_pre_valid", 64'(m_ar_valid), 64'd0);
         chk("vec_aw_pre_valid", 64'(m_aw_valid), 64'd0);
         chk("vec_s_ar_ready", 64'(s_ar_ready), 64'd1);
         tick();
         s_ar_valid = 0; s_aw_valid = 0;
         #2;
         chk("vec_m_ar_valid", 64'(m_ar_valid), 64'd1);
         chk("vec_m_ar_addr",  64'(m_ar_addr),  64'(vecs[i].exp_addr));
         chk("vec_m_ar_id",    64'(m_ar_id),    64'(vecs[i].id));
         chk("vec_m_ar_len",   64'(m_ar_len),   64'(vecs[i].len));
         chk("vec_m_ar_size",  64'(m_ar_size),  64'(vecs[i].size));
         chk("vec_m_ar_burst", 64'(m_ar_burst), 64'd1);
         chk("vec_m_aw_valid", 64'(m_aw_valid), 64'd1);
         chk("vec_m_aw_addr",  64'(m_aw_addr),  64'(vecs[i].exp_addr));
         chk("vec_m_aw_id",    64'(m_aw_id),    64'(vecs[i].id));
         chk("vec_m_aw_burst", 64'(m_aw_burst), 64'd1);
         tick();
         #2;
         chk("vec_ar_post_valid", 64'(m_ar_valid), 64'd0);
         chk("vec_rd_cnt_one", 64'(dbg_rd_cnt), 64'd1);
         chk("vec_wr_cnt_one", 64'(dbg_wr_cnt), 64'd1);
         tick();
         m_r_valid = 1; m_r_last = 1; s_r_ready = 1; m_r_data = {$urandom, $urandom};
         m_r_id = 6'(i + 7); m_r_resp = 2'(i);
         m_b_valid = 1; s_b_ready = 1; m_b_id = 6'(i + 11); m_b_resp = 2'(3 - i % 4);
         #2;
         chk("vec_s_r_valid", 64'(s_r_valid), 64'd1);
         chk("vec_s_r_data",  s_r_data, m_r_data);
         chk("vec_s_r_id",    64'(s_r_id), 64'(i + 7));
         chk("vec_s_r_last",  64'(s_r_last), 64'd1);
         chk("vec_s_r_resp",  64'(s_r_resp), 64'(i % 4));
         chk("vec_m_r_ready", 64'(m_r_ready), 64'd1);
         chk("vec_s_b_id",    64'(s_b_id), 64'(i + 11));
         chk("vec_s_b_resp",  64'(s_b_resp), 64'(3 - i % 4));
         chk("vec_m_b_ready", 64'(m_b_ready), 64'd1);
         tick();
         m_r_valid = 0; m_r_last = 0; m_b_valid = 0;
         #2;
         chk("vec_rd_cnt_zero", 64'(dbg_rd_cnt), 64'd0);
         chk("vec_wr_cnt_zero", 64'(dbg_wr_cnt), 64'd0);
         tick();
      end

      // ---- nine ARs against a stalled R channel ----
      do_reset();
      m_ar_ready = 1;
      base = ar_hs_cnt;
      for (int i = 0; i < 9; i++) send_ar(32'h0000_1000 + 32'(i * 64), 6'(i), 8'd3);
      repeat (5) tick();
      #2;
      chk("stall_hs_count", 64'(ar_hs_cnt - base), 64'd8);
      chk("stall_rd_cnt", 64'(dbg_rd_cnt), 64'(MAX_OUT));
      chk("stall_m_ar_valid", 64'(m_ar_valid), 64'd0);
      chk("stall_ar_full", 64'(dbg_ar_full), 64'd1);
      chk("stall_s_ar_ready", 64'(s_ar_ready), 64'd0);
      tick();
      m_r_valid = 1; m_r_last = 1; s_r_ready = 1;
      tick();
      m_r_valid = 0; m_r_last = 0;
      #2;
      chk("stall_release_valid", 64'(m_ar_valid), 64'd1);
      tick();
      #2;
      chk("stall_hs_ninth", 64'(ar_hs_cnt - base), 64'd9);
      chk("stall_rd_cnt_refill", 64'(dbg_rd_cnt), 64'(MAX_OUT));

      // ---- W presented before its AW ----
      do_reset();
      m_aw_ready = 1; m_w_ready = 1; s_w_valid = 1; s_w_data = 64'hDEAD_BEEF_0000_0001;
      for (int i = 0; i < 4; i++) wdata[i] = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("w_early_valid", 64'(m_w_valid), 64'd0);
         chk("w_early_ready", 64'(s_w_ready), 64'd0);
         tick();
      end
      s_aw_valid = 1; s_aw_addr = 32'h0400_0000; s_aw_id = 6'd9; s_aw_len = 8'd3; s_aw_size = 3'd3;
      #2;
      chk("w_aw_capture_cycle", 64'(m_w_valid), 64'd0);
      tick();
      s_aw_valid = 0;
      #2;
      chk("w_aw_hs_cycle_aw", 64'(m_aw_valid), 64'd1);
      chk("w_aw_hs_cycle_w", 64'(m_w_valid), 64'd0);
      tick();
      for (int b = 0; b < 4; b++) begin
         s_w_data = wdata[b]; s_w_last = (b == 3);
         #2;
         if (b == 0) chk("w_wb_cnt_one", 64'(dbg_wb_cnt), 64'd1);
         chk("w_beat_valid", 64'(m_w_valid), 64'd1);
         chk("w_beat_ready", 64'(s_w_ready), 64'd1);
         chk("w_beat_data",  m_w_data, wdata[b]);
         chk("w_beat_last",  64'(m_w_last), 64'(b == 3));
         chk("w_beat_strb",  64'(m_w_strb), 64'hFF);
         tick();
      end
      s_w_valid = 0; s_w_last = 0;
      #2;
      chk("w_wb_cnt_done", 64'(dbg_wb_cnt), 64'd0);
      chk("w_closed", 64'(s_w_ready), 64'd0);
      tick();

      // ---- simultaneous AW grant and B at wr_cnt = 3 ----
      do_reset();
      m_aw_ready = 1;
      for (int i = 0; i < 3; i++) send_aw(32'h0000_2000 + 32'(i * 256), 6'(i), 8'd0);
      tick();
      m_aw_ready = 0;
      #2;
      chk("sim_wr_cnt_pre", 64'(dbg_wr_cnt), 64'd3);
      tick();
      send_aw(32'h0000_3000, 6'd4, 8'd0);
      m_aw_ready = 1; m_b_valid = 1; s_b_ready = 1; m_b_id = 6'd5; m_b_resp = 2'd2;
      #2;
      chk("sim_m_aw_valid", 64'(m_aw_valid), 64'd1);
      chk("sim_s_b_valid", 64'(s_b_valid), 64'd1);
      chk("sim_s_b_id", 64'(s_b_id), 64'd5);
      tick();
      m_aw_ready = 0; m_b_valid = 0;
      #2;
      chk("sim_wr_cnt_post", 64'(dbg_wr_cnt), 64'd3);
      chk("sim_aw_drained", 64'(m_aw_valid), 64'd0);
      tick();

      // ---- asynchronous reset with reads outstanding and AR slice full ----
      do_reset();
      m_ar_ready = 1;
      send_ar(32'h0000_4000, 6'd1, 8'd1);
      send_ar(32'h0000_4100, 6'd2, 8'd1);
      tick();
      m_ar_ready = 0;
      send_ar(32'h0000_4200, 6'd3, 8'd1);
      #2;
      chk("mid_rd_cnt", 64'(dbg_rd_cnt), 64'd2);
      chk("mid_m_ar_valid", 64'(m_ar_valid), 64'd1);
      s_ar_valid = 1; s_aw_valid = 1; s_w_valid = 1;
      m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1;
      reset_n = 0;
      #1;
      chk("mid_rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
      chk("mid_rst_s_aw_ready", 64'(s_aw_ready), 64'd0);
      chk("mid_rst_s_w_ready",  64'(s_w_ready),  64'd0);
      chk("mid_rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
      chk("mid_rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
      chk("mid_rst_m_w_valid",  64'(m_w_valid),  64'd0);
      tick();
      idle_inputs();
      tick();
      reset_n = 1;
      #2;
      chk("mid_post_rd_cnt", 64'(dbg_rd_cnt), 64'd0);
      chk("mid_post_ar_full", 64'(dbg_ar_full), 64'd0);
      chk("mid_post_m_ar_valid", 64'(m_ar_valid), 64'd0);
      tick();

`ifdef DDR_HP_BRIDGE_STATS_EN
      // ---- statistics: five reads, three writes ----
      do_reset();
      m_ar_ready = 1; m_aw_ready = 1;
      for (int i = 0; i < 5; i++) send_ar(32'h0000_5000 + 32'(i * 64), 6'(i), 8'd0);
      for (int i = 0; i < 3; i++) send_aw(32'h0000_6000 + 32'(i * 64), 6'(i), 8'd0);
      tick();
      tick();
      #2;
      chk("stat_rd_bursts", 64'(stat_rd_bursts), 64'd5);
      chk("stat_wr_bursts", 64'(stat_wr_bursts), 64'd3);
      tick();
`endif

      // ---- randomized run against the transaction model ----
      do_reset();
      ar_q.delete(); aw_q.delete();
      rd_out = 0; wr_out = 0; wb_out = 0; st_rd = 0; st_wr = 0;
      for (int c = 0; c < 1500; c++) begin
         bit exp_ar_mv, exp_ar_sr, exp_aw_mv, exp_aw_sr, exp_wv, exp_wr;
         bit ar_m, ar_s, aw_m, aw_s, r_last, b_done, w_last;

         s_ar_valid = ($urandom_range(0, 1) == 1); s_ar_addr = $urandom;
         s_ar_id = 6'($urandom); s_ar_len = 8'($urandom); s_ar_size = 3'($urandom);
         s_aw_valid = ($urandom_range(0, 1) == 1); s_aw_addr = $urandom;
         s_aw_id = 6'($urandom); s_aw_len = 8'($urandom); s_aw_size = 3'($urandom);
         m_ar_ready = ($urandom_range(0, 3) != 0);
         m_aw_ready = ($urandom_range(0, 3) != 0);
         s_w_valid = ($urandom_range(0, 3) != 0); s_w_last = ($urandom_range(0, 2) == 0);
         s_w_data = {$urandom, $urandom};
         m_w_ready = ($urandom_range(0, 3) != 0);
         m_r_valid = ($urandom_range(0, 2) == 0); m_r_last = ($urandom_range(0, 1) == 1);
         m_r_data = {$urandom, $urandom}; m_r_id = 6'($urandom); m_r_resp = 2'($urandom);
         s_r_ready = ($urandom_range(0, 3) != 0);
         m_b_valid = ($urandom_range(0, 3) == 0); m_b_id = 6'($urandom); m_b_resp = 2'($urandom);
         s_b_ready = ($urandom_range(0, 3) != 0);
         #2;

         exp_ar_mv = (ar_q.size() != 0) && (rd_out < MAX_OUT);
         exp_ar_sr = (ar_q.size() == 0) || (exp_ar_mv && m_ar_ready);
         exp_aw_mv = (aw_q.size() != 0) && (wr_out < MAX_OUT);
         exp_aw_sr = (aw_q.size() == 0) || (exp_aw_mv && m_aw_ready);
         exp_wv = s_w_valid && (wb_out != 0);
         exp_wr = m_w_ready && (wb_out != 0);

         chk("rnd_m_ar_valid", 64'(m_ar_valid), 64'(exp_ar_mv));
         chk("rnd_s_ar_ready", 64'(s_ar_ready), 64'(exp_ar_sr));
         chk("rnd_m_aw_valid", 64'(m_aw_valid), 64'(exp_aw_mv));
         chk("rnd_s_aw_ready", 64'(s_aw_ready), 64'(exp_aw_sr));
         if (exp_ar_mv) begin
            chk("rnd_m_ar_addr", 64'(m_ar_addr), 64'((ar_q[0].addr & 32'h0FFF_FFFF) | 32'h1000_0000));
            chk("rnd_m_ar_id",   64'(m_ar_id),   64'(ar_q[0].id));
            chk("rnd_m_ar_len",  64'(m_ar_len),  64'(ar_q[0].len));
            chk("rnd_m_ar_size", 64'(m_ar_size), 64'(ar_q[0].size));
         end
         if (exp_aw_mv) begin
            chk("rnd_m_aw_addr", 64'(m_aw_addr), 64'((aw_q[0].addr & 32'h0FFF_FFFF) | 32'h1000_0000));
            chk("rnd_m_aw_id",   64'(m_aw_id),   64'(aw_q[0].id));
            chk("rnd_m_aw_len",  64'(m_aw_len),  64'(aw_q[0].len));
         end
         chk("rnd_m_w_valid", 64'(m_w_valid), 64'(exp_wv));
         chk("rnd_s_w_ready", 64'(s_w_ready), 64'(exp_wr));
         if (exp_wv) chk("rnd_m_w_data", m_w_data, s_w_data);
         chk("rnd_s_r_valid", 64'(s_r_valid), 64'(m_r_valid));
         chk("rnd_m_r_ready", 64'(m_r_ready), 64'(s_r_ready));
         if (m_r_valid) begin
            chk("rnd_s_r_data", s_r_data, m_r_data);
            chk("rnd_s_r_id", 64'(s_r_id), 64'(m_r_id));
            chk("rnd_s_r_last", 64'(s_r_last), 64'(m_r_last));
         end
         chk("rnd_s_b_valid", 64'(s_b_valid), 64'(m_b_valid));
         chk("rnd_m_b_ready", 64'(m_b_ready), 64'(s_b_ready));
         chk("rnd_rd_cnt", 64'(dbg_rd_cnt), 64'(rd_out));
         chk("rnd_wr_cnt", 64'(dbg_wr_cnt), 64'(wr_out));
         chk("rnd_wb_cnt", 64'(dbg_wb_cnt), 64'(wb_out));

         ar_m   = exp_ar_mv && m_ar_ready;
         ar_s   = s_ar_valid && exp_ar_sr;
         aw_m   = exp_aw_mv && m_aw_ready;
         aw_s   = s_aw_valid && exp_aw_sr;
         r_last = m_r_valid && s_r_ready && m_r_last;
         b_done = m_b_valid && s_b_ready;
         w_last = exp_wv && m_w_ready && s_w_last;

         if (ar_m) void'(ar_q.pop_front());
         if (ar_s) ar_q.push_back('{addr: s_ar_addr, id: s_ar_id, len: s_ar_len, size: s_ar_size});
         if (aw_m) void'(aw_q.pop_front());
         if (aw_s) aw_q.push_back('{addr: s_aw_addr, id: s_aw_id, len: s_aw_len, size: s_aw_size});
         rd_out = clamp15(rd_out + int'(ar_m) - int'(r_last));
         wr_out = clamp15(wr_out + int'(aw_m) - int'(b_done));
         wb_out = clamp15(wb_out + int'(aw_m) - int'(w_last));
         st_rd += int'(ar_m);
         st_wr += int'(aw_m);
         tick();
      end
`ifdef DDR_HP_BRIDGE_STATS_EN
      #2;
      chk("rnd_stat_rd", 64'(stat_rd_bursts), 64'(st_rd));
      chk("rnd_stat_wr", 64'(stat_wr_bursts), 64'(st_wr));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
